// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu pattern sequencer: FSM states, pattern
// field layout and MISR constants (used when ALU_SEQ_MISR_EN is defined).
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        APPLY,
        MEASURE,
        DONE
    } seq_state_e;

    localparam int PI_W       = 5;
    localparam int ZOUT_W     = 2;
    localparam int OPND_W     = 2;
    // pat_pi layout: {ain[1:0], bin[1:0], sel}
    localparam int PI_SEL_BIT = 0;
    localparam int PI_BIN_LSB = 1;
    localparam int PI_AIN_LSB = 3;

    localparam int                MISR_W    = 8;
    localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;  // x^8 + x^4 + x^3 + x^2 + 1
    localparam logic [MISR_W-1:0] MISR_SEED = 8'hFF;

    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s,
                                                    input logic [MISR_W-1:0] d);
        return {s[MISR_W-2:0], 1'b0} ^ (s[MISR_W-1] ? MISR_POLY : '0) ^ d;
    endfunction

endpackage

// File: rtl/alu_resp_compare.sv
// Masked response compare for the alu under test; with ALU_SEQ_MISR_EN defined it
// also compacts the masked responses into an 8-bit MISR signature.
module alu_resp_compare
    import alu_seq_pkg::*;
(
`ifdef ALU_SEQ_MISR_EN
    input  logic              clk,
    input  logic              rst,
    input  logic              seed,
    input  logic              fold,
    output logic [MISR_W-1:0] sig,
`endif
    input  logic [ZOUT_W-1:0] zout,
    input  logic [ZOUT_W-1:0] xpct,
    input  logic [ZOUT_W-1:0] mask,
    output logic              mis
);

    logic [ZOUT_W-1:0] diff;

    // The if/else form makes an unknown on a compared bit land on the mismatch branch.
    always_comb begin
        diff = (zout ^ xpct) & mask;
        if (diff == '0) begin
            mis = 1'b0;
        end else begin
            mis = 1'b1;
        end
    end

`ifdef ALU_SEQ_MISR_EN
    logic [MISR_W-1:0] sig_d;
    logic [MISR_W-1:0] sig_q;

    always_comb begin
        sig_d = sig_q;
        if (seed) begin
            sig_d = MISR_SEED;
        end else if (fold) begin
            sig_d = misr_step(sig_q, {{(MISR_W-ZOUT_W){1'b0}}, zout & mask});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`endif

endmodule

// File: rtl/alu_pattern_sequencer.sv
// Applies stored patterns to the 2-bit alu, waits a settle window and counts masked
// mismatches on zout. Optional MISR signature port under ALU_SEQ_MISR_EN.
module alu_pattern_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NPAT   = 4,
    parameter int ADDR_W = 8,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              pat_req,
    output logic [ADDR_W-1:0] pat_addr,
    input  logic              pat_vld,
    input  logic [PI_W-1:0]   pat_pi,
    input  logic [ZOUT_W-1:0] pat_xpct,
    input  logic [ZOUT_W-1:0] pat_mask,
    output logic [OPND_W-1:0] alu_ain,
    output logic [OPND_W-1:0] alu_bin,
    output logic              alu_sel,
    input  logic [ZOUT_W-1:0] alu_zout,
`ifdef ALU_SEQ_MISR_EN
    output logic [MISR_W-1:0] sig,
`endif
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [ADDR_W-1:0] first_fail,
    output logic              first_fail_vld
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pat_addr_q, pat_addr_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [PI_W-1:0]   pi_q, pi_d;
    logic [ZOUT_W-1:0] xpct_q, xpct_d;
    logic [ZOUT_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic [ADDR_W-1:0] first_fail_q, first_fail_d;
    logic              first_fail_vld_q, first_fail_vld_d;
    logic              pass_q, pass_d;
    logic              mis;
    logic              run_start;
    logic              measure_en;

    assign run_start  = (state_q == IDLE) && start && !abort;
    assign measure_en = (state_q == MEASURE) && !abort;

    always_comb begin
        state_d          = state_q;
        pat_addr_d       = pat_addr_q;
        settle_cnt_d     = settle_cnt_q;
        pi_d             = pi_q;
        xpct_d           = xpct_q;
        mask_d           = mask_q;
        fail_cnt_d       = fail_cnt_q;
        first_fail_d     = first_fail_q;
        first_fail_vld_d = first_fail_vld_q;
        pass_d           = pass_q;

        if (abort) begin
            state_d = IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        fail_cnt_d       = '0;
                        first_fail_d     = '0;
                        first_fail_vld_d = 1'b0;
                        pass_d           = 1'b0;
                        pat_addr_d       = '0;
                        state_d          = FETCH;
                    end
                end
                FETCH: begin
                    if (pat_vld) begin
                        pi_d         = pat_pi;
                        xpct_d       = pat_xpct;
                        mask_d       = pat_mask;
                        settle_cnt_d = '0;
                        state_d      = APPLY;
                    end
                end
                APPLY: begin
                    if (settle_cnt_q == SET_W'(SETTLE - 1)) begin
                        state_d = MEASURE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                MEASURE: begin
                    if (mis) begin
                        fail_cnt_d = sat_inc(fail_cnt_q);
                        if (!first_fail_vld_q) begin
                            first_fail_d     = pat_addr_q;
                            first_fail_vld_d = 1'b1;
                        end
                    end
                    // pass is settled here so it is already valid while done is high
                    if (pat_addr_q == ADDR_W'(NPAT - 1)) begin
                        pass_d  = (fail_cnt_d == '0);
                        state_d = DONE;
                    end else begin
                        pat_addr_d = pat_addr_q + 1'b1;
                        state_d    = FETCH;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            pat_addr_q       <= '0;
            settle_cnt_q     <= '0;
            pi_q             <= '0;
            xpct_q           <= '0;
            mask_q           <= '0;
            fail_cnt_q       <= '0;
            first_fail_q     <= '0;
            first_fail_vld_q <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            pat_addr_q       <= pat_addr_d;
            settle_cnt_q     <= settle_cnt_d;
            pi_q             <= pi_d;
            xpct_q           <= xpct_d;
            mask_q           <= mask_d;
            fail_cnt_q       <= fail_cnt_d;
            first_fail_q     <= first_fail_d;
            first_fail_vld_q <= first_fail_vld_d;
            pass_q           <= pass_d;
        end
    end

    alu_resp_compare u_cmp (
`ifdef ALU_SEQ_MISR_EN
        .clk  (clk),
        .rst  (rst),
        .seed (run_start),
        .fold (measure_en),
        .sig  (sig),
`endif
        .zout (alu_zout),
        .xpct (xpct_q),
        .mask (mask_q),
        .mis  (mis)
    );

    assign busy           = (state_q == FETCH) || (state_q == APPLY) || (state_q == MEASURE);
    assign done           = (state_q == DONE);
    assign pat_req        = (state_q == FETCH);
    assign pass           = pass_q;
    assign pat_addr       = pat_addr_q;
    assign alu_ain        = pi_q[PI_AIN_LSB +: OPND_W];
    assign alu_bin        = pi_q[PI_BIN_LSB +: OPND_W];
    assign alu_sel        = pi_q[PI_SEL_BIT];
    assign fail_cnt       = fail_cnt_q;
    assign first_fail     = first_fail_q;
    assign first_fail_vld = first_fail_vld_q;

    // measure_en is only consumed by the MISR build
    logic unused_ok;
    assign unused_ok = measure_en ^ run_start;

endmodule

// File: tb/tb_alu_pattern_sequencer.sv
// Directed bench for alu_pattern_sequencer: golden alu plus fault injection, a pattern
// store replying one cycle after pat_req, and hand-computed expectations.
module tb_alu_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort;
    logic       busy, done, pass, pat_req;
    logic [7:0] pat_addr;
    logic       pat_vld;
    logic [4:0] pat_pi;
    logic [1:0] pat_xpct, pat_mask;
    logic [1:0] alu_ain, alu_bin;
    logic       alu_sel;
    logic [1:0] alu_zout;
    logic [7:0] fail_cnt, first_fail;
    logic       first_fail_vld;
`ifdef ALU_SEQ_MISR_EN
    logic [7:0] sig;
`endif

    int errors = 0;
    int checks = 0;

    logic [4:0] pi_tab   [4] = '{5'b11101, 5'b01101, 5'b01111, 5'b00111};
    logic [1:0] xpct_tab [4] = '{2'b10, 2'b00, 2'b01, 2'bx0};
    logic [1:0] mask_tab [4] = '{2'b11, 2'b11, 2'b11, 2'b01};

    bit stuck1    = 1'b0;
    bit toggle_en = 1'b0;
    bit delay_en  = 1'b0;
    bit tog       = 1'b0;

    always #5 clk = ~clk;

    alu_pattern_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .pat_req        (pat_req),
        .pat_addr       (pat_addr),
        .pat_vld        (pat_vld),
        .pat_pi         (pat_pi),
        .pat_xpct       (pat_xpct),
        .pat_mask       (pat_mask),
        .alu_ain        (alu_ain),
        .alu_bin        (alu_bin),
        .alu_sel        (alu_sel),
        .alu_zout       (alu_zout),
`ifdef ALU_SEQ_MISR_EN
        .sig            (sig),
`endif
        .fail_cnt       (fail_cnt),
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld)
    );

    function automatic logic [1:0] alu_fn(input logic [1:0] a, input logic [1:0] b, input logic s);
        return s ? (a & b) : (a | b);
    endfunction

    // Golden alu with optional stuck-at-1 and toggling faults on zout[1]
    always_comb begin
        alu_zout = alu_fn(alu_ain, alu_bin, alu_sel);
        if (stuck1) alu_zout[1] = 1'b1;
        if (toggle_en && pat_addr == 8'd3) alu_zout[1] = tog;
    end

    // Pattern store: pat_vld one cycle after pat_req (six cycles for pattern 2 when delayed)
    initial begin
        int req_cnt;
        int thr;
        req_cnt  = 0;
        pat_vld  = 1'b0;
        pat_pi   = '0;
        pat_xpct = '0;
        pat_mask = '0;
        forever begin
            @(negedge clk);
            tog = ~tog;
            if (pat_req && pat_addr < 8'd4) begin
                req_cnt++;
                thr      = (delay_en && pat_addr == 8'd2) ? 6 : 1;
                pat_pi   = pi_tab[pat_addr[1:0]];
                pat_xpct = xpct_tab[pat_addr[1:0]];
                pat_mask = mask_tab[pat_addr[1:0]];
                pat_vld  = (req_cnt >= thr);
            end else begin
                req_cnt = 0;
                pat_vld = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start, then wait (bounded) for done; lat counts cycles from the start edge.
    task automatic run(input string tag, output int lat, output bit got);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_start_addr"}, {pat_req, pat_addr}, {1'b1, 8'd0});
        lat = 1;
        got = 1'b0;
        while (!got && lat < 200) begin
            if (done) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({tag, "_done_seen"}, got, 1);
    endtask

    task automatic check_done_pulse(input string tag);
        @(negedge clk);
        check({tag, "_done_1cyc"}, {done, busy}, 2'b00);
    endtask

`ifdef ALU_SEQ_MISR_EN
    function automatic logic [7:0] misr_model();
        logic [7:0] s;
        logic [7:0] n;
        s = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            n = {s[6:0], 1'b0};
            if (s[7]) n = n ^ 8'h1D;
            s = n ^ {6'b0, alu_fn(pi_tab[i][4:3], pi_tab[i][2:1], pi_tab[i][0]) & mask_tab[i]};
        end
        return s;
    endfunction
`endif

    initial begin
        int lat;
        bit got;
        int n;
        int k;
        int dcnt;

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        #12;
        check("rst_ctrl", {busy, done, pass, pat_req, first_fail_vld}, 5'b0);
        check("rst_addr", pat_addr, 0);
        check("rst_alu", {alu_ain, alu_bin, alu_sel}, 5'b0);
        check("rst_cnt", {fail_cnt, first_fail}, 16'h0);
        @(negedge clk) rst = 1'b0;

        // 1: golden alu, all patterns pass
        run("s1", lat, got);
        check("s1_latency", lat, 17);
        check("s1_pass", pass, 1);
        check("s1_fail_cnt", fail_cnt, 0);
        check("s1_ffv", first_fail_vld, 0);
`ifdef ALU_SEQ_MISR_EN
        check("s1_sig", sig, misr_model());
`endif
        check_done_pulse("s1");

        // 2: zout[1] stuck-at-1 -> patterns 1 and 2 fail
        stuck1 = 1'b1;
        run("s2", lat, got);
        stuck1 = 1'b0;
        check("s2_fail_cnt", fail_cnt, 2);
        check("s2_first_fail", {first_fail_vld, first_fail}, {1'b1, 8'd1});
        check("s2_pass", pass, 0);
        check_done_pulse("s2");

        // 3: toggling zout[1] on pattern 3 is masked out
        toggle_en = 1'b1;
        run("s3", lat, got);
        toggle_en = 1'b0;
        check("s3_fail_cnt", fail_cnt, 0);
        check("s3_pass", {pass, first_fail_vld}, 2'b10);

        // 4: pattern 2 data arrives five cycles late
        delay_en = 1'b1;
        fork
            run("s4", lat, got);
            begin
                n = 0;
                while (!(pat_req && pat_addr == 8'd2) && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                repeat (3) @(negedge clk);
                check("s4_wait_req", {pat_req, pat_addr}, {1'b1, 8'd2});
                check("s4_alu_held", {alu_ain, alu_bin, alu_sel}, 5'b01101);
            end
        join
        delay_en = 1'b0;
        check("s4_latency", lat, 22);
        check("s4_result", {pass, fail_cnt, first_fail_vld}, {1'b1, 8'd0, 1'b0});

        // 5: abort during APPLY of pattern 1
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!(busy && !pat_req && pat_addr == 8'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("s5_reach_apply", n < 100, 1);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("s5_idle", {busy, done, pat_req, pass}, 4'b0);
        check("s5_addr_kept", pat_addr, 1);
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("s5_no_done", dcnt, 0);
        run("s5r", lat, got);
        check("s5_rerun", {pass, fail_cnt}, {1'b1, 8'd0});
        check("s5_rerun_lat", lat, 17);

        // 6: async reset while measuring pattern 2
        stuck1 = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        n = 0;
        while (k < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (busy && !pat_req && pat_addr == 8'd2) k++;
        end
        check("s6_reach_measure", k, 3);
        check("s6_pre_cnt", {fail_cnt, first_fail_vld}, {8'd1, 1'b1});
        rst = 1'b1;
        #1;
        check("s6_rst_ctrl", {busy, done, pass, pat_req, first_fail_vld}, 5'b0);
        check("s6_rst_data", {pat_addr, fail_cnt, first_fail}, 24'h0);
        check("s6_rst_alu", {alu_ain, alu_bin, alu_sel}, 5'b0);
        stuck1 = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("s6_stay_idle", {busy, done}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
